// File: rtl/fruit_motion.sv
// ----------------------------------------------------------------------------
// fruit_motion
//
// Motion controller for a single thrown fruit sprite. A fruit is launched from
// the bottom of the screen with a starting horizontal and vertical velocity.
// It then flies under constant gravity, bounces off the left and right walls,
// and clamps at the top edge. The flight ends in one of two ways:
//   - the fruit falls back to the bottom edge unsliced, which pulses 'missed'
//   - a slice is detected, which pulses 'sliced' and freezes the sprite for
//     HOLD_FRAMES frames before it disappears
// Position updates happen once per video frame, on the rising edge of the
// vsync-derived frame strobe after it has been sampled into the Clk domain.
//
// Ports
//   Clk          system clock, all state changes on its rising edge
//   Reset_n      asynchronous active-low reset
//   frame_clk    frame strobe, sampled on Clk and edge-detected
//   launch       level request to throw a new fruit (honoured only when idle)
//   launch_x     starting left edge, clamped to SCREEN_W-SIZE
//   launch_vx    signed starting horizontal velocity (pixels/frame)
//   launch_vy    signed starting vertical velocity (negative is upward)
//   slice_hit    a slice touched this fruit
//   FruitX       fruit left edge for the color mapper
//   FruitY       fruit top edge for the color mapper
//   Fruit_size   SIZE while the fruit is drawn, 0 when idle
//   busy         high whenever a fruit is flying or being held after a slice
//   sliced       one-Clk pulse when a slice is accepted
//   missed       one-Clk pulse when the fruit drops out unsliced
// ----------------------------------------------------------------------------
module fruit_motion #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SIZE        = 32,
    parameter int GRAVITY     = 1,
    parameter int HOLD_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       launch,
    input  logic [9:0] launch_x,
    input  logic [5:0] launch_vx,
    input  logic [5:0] launch_vy,
    input  logic       slice_hit,
    output logic [9:0] FruitX,
    output logic [9:0] FruitY,
    output logic [9:0] Fruit_size,
    output logic       busy,
    output logic       sliced,
    output logic       missed
);

    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [9:0]          X_MAX      = 10'(SCREEN_W - SIZE);
    localparam logic [9:0]          Y_BOTTOM   = 10'(SCREEN_H - SIZE);
    localparam logic [9:0]          SIZE_PX    = 10'(SIZE);
    localparam logic signed [11:0]  X_MAX_S    = 12'(SCREEN_W - SIZE);
    localparam logic signed [11:0]  Y_BOTTOM_S = 12'(SCREEN_H - SIZE);
    localparam logic signed [11:0]  VY_CAP     = 12'sd31;
    localparam logic signed [11:0]  GRAVITY_S  = 12'(GRAVITY);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        SLICED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 frameSync_q, frameDly_q;
    logic                 frameTick;
    logic [9:0]           posX_q, posX_d;
    logic [9:0]           posY_q, posY_d;
    logic signed [5:0]    velX_q, velX_d;
    logic signed [5:0]    velY_q, velY_d;
    logic [HOLD_W-1:0]    holdCnt_q, holdCnt_d;
    logic [9:0]           size_q, size_d;
    logic                 busy_q, busy_d;
    logic                 sliced_q, sliced_d;
    logic                 missed_q, missed_d;

    logic signed [11:0]   curX, curY, velX12, velY12;
    logic signed [11:0]   nextX, nextY, nextVy;
    logic signed [5:0]    cappedVy;

    // The frame strobe comes from the video timing and is not aligned to Clk.
    // It is captured once, and a second register holds the previous sample so
    // that a rising edge of the captured strobe yields exactly one Clk of tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frameSync_q <= 1'b0;
            frameDly_q  <= 1'b0;
        end else begin
            frameSync_q <= frame_clk;
            frameDly_q  <= frameSync_q;
        end
    end

    assign frameTick = frameSync_q & ~frameDly_q;

    // Candidate next position and velocity, worked out in 12-bit signed so
    // that moves past the left/top edge show up as negative values instead of
    // wrapping around. Vertical velocity saturates at +31 so the 6-bit
    // register never overflows while the fruit keeps accelerating downward.
    assign curX     = $signed({2'b00, posX_q});
    assign curY     = $signed({2'b00, posY_q});
    assign velX12   = {{6{velX_q[5]}}, velX_q};
    assign velY12   = {{6{velY_q[5]}}, velY_q};
    assign nextX    = curX + velX12;
    assign nextY    = curY + velY12;
    assign nextVy   = velY12 + GRAVITY_S;
    assign cappedVy = (nextVy > VY_CAP) ? 6'sd31 : nextVy[5:0];

    // Next-state and datapath logic. A slice always wins over a frame tick in
    // the same cycle, so a sliced fruit is frozen where it was last drawn and
    // can never also be reported as missed. The wall bounce reflects the
    // horizontal velocity; the top edge only clamps position, gravity keeps
    // working so the fruit falls back down naturally.
    always_comb begin
        state_d   = state_q;
        posX_d    = posX_q;
        posY_d    = posY_q;
        velX_d    = velX_q;
        velY_d    = velY_q;
        holdCnt_d = holdCnt_q;
        sliced_d  = 1'b0;
        missed_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    posX_d  = (launch_x > X_MAX) ? X_MAX : launch_x;
                    posY_d  = Y_BOTTOM;
                    velX_d  = launch_vx;
                    velY_d  = launch_vy;
                    state_d = FLIGHT;
                end
            end

            FLIGHT: begin
                if (slice_hit) begin
                    sliced_d  = 1'b1;
                    holdCnt_d = '0;
                    state_d   = SLICED;
                end else if (frameTick) begin
                    if (nextX < 12'sd0) begin
                        posX_d = 10'd0;
                        velX_d = -velX_q;
                    end else if (nextX > X_MAX_S) begin
                        posX_d = X_MAX;
                        velX_d = -velX_q;
                    end else begin
                        posX_d = nextX[9:0];
                    end

                    if (nextY < 12'sd0) begin
                        posY_d = 10'd0;
                    end else begin
                        posY_d = nextY[9:0];
                    end

                    velY_d = cappedVy;

                    // Only a fruit that is already falling can leave through
                    // the bottom; the launch point itself sits on that line.
                    if ((velY_q > 6'sd0) && (nextY >= Y_BOTTOM_S)) begin
                        missed_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            SLICED: begin
                if (frameTick) begin
                    if (holdCnt_q == HOLD_LAST) begin
                        holdCnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        holdCnt_d = holdCnt_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);
    assign size_d = (state_d != IDLE) ? SIZE_PX : 10'd0;

    // State, motion registers and the registered outputs. Reset abandons any
    // fruit in flight silently: no pulse is produced and the sprite vanishes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            posX_q    <= 10'd0;
            posY_q    <= Y_BOTTOM;
            velX_q    <= 6'sd0;
            velY_q    <= 6'sd0;
            holdCnt_q <= '0;
            size_q    <= 10'd0;
            busy_q    <= 1'b0;
            sliced_q  <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            posX_q    <= posX_d;
            posY_q    <= posY_d;
            velX_q    <= velX_d;
            velY_q    <= velY_d;
            holdCnt_q <= holdCnt_d;
            size_q    <= size_d;
            busy_q    <= busy_d;
            sliced_q  <= sliced_d;
            missed_q  <= missed_d;
        end
    end

    assign FruitX     = posX_q;
    assign FruitY     = posY_q;
    assign Fruit_size = size_q;
    assign busy       = busy_q;
    assign sliced     = sliced_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_fruit_motion.sv
// ----------------------------------------------------------------------------
// tb_fruit_motion
//
// Testbench for fruit_motion. A driver issues directed scenarios followed by
// randomized traffic; on every Clk edge a behavioural model of the fruit
// (plain integer physics) predicts the registered outputs and queues them.
// An independent monitor pops one prediction per cycle and compares it with
// what the design shows. Directed scenarios additionally check hand-computed
// positions and pulse timing.
// ----------------------------------------------------------------------------
module tb_fruit_motion;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int S  = 32;
    localparam int G  = 1;
    localparam int HF = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       launch = 1'b0;
    logic [9:0] launch_x = '0;
    logic [5:0] launch_vx = '0;
    logic [5:0] launch_vy = '0;
    logic       slice_hit = 1'b0;
    logic [9:0] FruitX, FruitY, Fruit_size;
    logic       busy, sliced, missed;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] size;
        logic       busy;
        logic       sliced;
        logic       missed;
    } snap_t;

    snap_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    bit    sawMissed = 0;
    bit    sawSliced = 0;

    // Reference model state: the fruit as a few integers plus two flags.
    bit mFlying, mHolding;
    int mX, mY, mVx, mVy, mFramesLeft;
    bit fcLast, fcPrev;

    fruit_motion #(
        .SCREEN_W(W), .SCREEN_H(H), .SIZE(S), .GRAVITY(G), .HOLD_FRAMES(HF)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .launch(launch),
        .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
        .slice_hit(slice_hit), .FruitX(FruitX), .FruitY(FruitY),
        .Fruit_size(Fruit_size), .busy(busy), .sliced(sliced), .missed(missed)
    );

    always #5 Clk = ~Clk;

    // Model: everything back to the power-on picture.
    function automatic void modelReset();
        mFlying     = 0;
        mHolding    = 0;
        mX          = 0;
        mY          = H - S;
        mVx         = 0;
        mVy         = 0;
        mFramesLeft = 0;
        fcLast      = 0;
        fcPrev      = 0;
    endfunction

    // Model: one Clk edge. A frame counts when the strobe was seen high at the
    // previous edge and low at the one before. The result is queued.
    function automatic void modelStep();
        bit    tick;
        bit    pSliced = 0;
        bit    pMissed = 0;
        int    nx, ny, oldVy, lx;
        snap_t e;
        if (!Reset_n) begin
            modelReset();
        end else begin
            tick   = fcLast && !fcPrev;
            fcPrev = fcLast;
            fcLast = (frame_clk === 1'b1);
            if (!mFlying && !mHolding) begin
                if (launch) begin
                    lx      = int'(launch_x);
                    mX      = (lx > W - S) ? W - S : lx;
                    mY      = H - S;
                    mVx     = int'($signed(launch_vx));
                    mVy     = int'($signed(launch_vy));
                    mFlying = 1;
                end
            end else if (mFlying) begin
                if (slice_hit) begin
                    pSliced     = 1;
                    mFlying     = 0;
                    mHolding    = 1;
                    mFramesLeft = HF;
                end else if (tick) begin
                    nx    = mX + mVx;
                    ny    = mY + mVy;
                    oldVy = mVy;
                    mVy   = (mVy + G > 31) ? 31 : mVy + G;
                    if (nx < 0) begin
                        mX  = 0;
                        mVx = -mVx;
                    end else if (nx > W - S) begin
                        mX  = W - S;
                        mVx = -mVx;
                    end else begin
                        mX = nx;
                    end
                    mY = (ny < 0) ? 0 : ny;
                    if (oldVy > 0 && ny >= H - S) begin
                        pMissed = 1;
                        mFlying = 0;
                    end
                end
            end else if (tick) begin
                mFramesLeft--;
                if (mFramesLeft == 0) mHolding = 0;
            end
        end
        e.x      = 10'(mX);
        e.y      = 10'(mY);
        e.size   = (mFlying || mHolding) ? 10'(S) : 10'd0;
        e.busy   = mFlying || mHolding;
        e.sliced = pSliced;
        e.missed = pMissed;
        expQ.push_back(e);
    endfunction

    // One Clk cycle with the inputs currently driven; returns at the negedge.
    task automatic applyStimulus();
        @(posedge Clk);
        modelStep();
        @(negedge Clk);
        if (missed === 1'b1) sawMissed = 1;
        if (sliced === 1'b1) sawSliced = 1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One full frame: strobe high for three cycles, low for three.
    task automatic frame();
        frame_clk = 1'b1;
        repeat (3) applyStimulus();
        frame_clk = 1'b0;
        repeat (3) applyStimulus();
    endtask

    task automatic launchFruit(input int x, input int vx, input int vy);
        launch    = 1'b1;
        launch_x  = 10'(x);
        launch_vx = 6'(vx);
        launch_vy = 6'(vy);
        applyStimulus();
        launch    = 1'b0;
    endtask

    // Keep producing frames until the fruit is gone, bounded.
    task automatic flyOut(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            frame();
            n++;
        end
        checkOutput(name, int'(busy), 0);
    endtask

    // Monitor: one queued prediction is compared on every falling edge.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge Clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                a = {FruitX, FruitY, Fruit_size, busy, sliced, missed};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("[TB] FAIL scoreboard t=%0t: got x=%0d y=%0d size=%0d busy=%b sliced=%b missed=%b, expected x=%0d y=%0d size=%0d busy=%b sliced=%b missed=%b",
                             $time, a.x, a.y, a.size, a.busy, a.sliced, a.missed,
                             e.x, e.y, e.size, e.busy, e.sliced, e.missed);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int missTick;
        int v;
        modelReset();
        repeat (3) applyStimulus();
        checkOutput("resetX", int'(FruitX), 0);
        checkOutput("resetY", int'(FruitY), 448);
        checkOutput("resetSize", int'(Fruit_size), 0);
        checkOutput("resetBusy", int'(busy), 0);
        Reset_n = 1'b1;
        applyStimulus();

        // Basic ballistic flight ending in a miss at frame 21.
        launchFruit(100, 3, -10);
        applyStimulus();
        frame();
        checkOutput("tick1X", int'(FruitX), 103);
        checkOutput("tick1Y", int'(FruitY), 438);
        frame();
        checkOutput("tick2X", int'(FruitX), 106);
        checkOutput("tick2Y", int'(FruitY), 429);
        sawMissed = 0;
        missTick  = 0;
        for (int t = 3; t <= 30 && missTick == 0; t++) begin
            frame();
            if (sawMissed) missTick = t;
        end
        checkOutput("missTick", missTick, 21);
        checkOutput("missY", int'(FruitY), 448);
        checkOutput("missBusy", int'(busy), 0);
        checkOutput("missSize", int'(Fruit_size), 0);

        // Right wall bounce.
        launchFruit(600, 5, -20);
        frame();
        checkOutput("wallTick1X", int'(FruitX), 605);
        frame();
        checkOutput("wallTick2X", int'(FruitX), 608);
        frame();
        checkOutput("wallTick3X", int'(FruitX), 603);
        flyOut("wallFlyOut");

        // Launch X beyond the right limit is clamped.
        launchFruit(1000, 0, -4);
        checkOutput("clampX", int'(FruitX), 608);
        flyOut("clampFlyOut");

        // Slice coinciding with the fifth frame tick.
        sawMissed = 0;
        launchFruit(100, 3, -10);
        applyStimulus();
        repeat (4) frame();
        checkOutput("preSliceX", int'(FruitX), 112);
        checkOutput("preSliceY", int'(FruitY), 414);
        sawSliced = 0;
        frame_clk = 1'b1;
        applyStimulus();
        slice_hit = 1'b1;
        applyStimulus();
        slice_hit = 1'b0;
        applyStimulus();
        frame_clk = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("slicePulse", int'(sawSliced), 1);
        checkOutput("sliceX", int'(FruitX), 112);
        checkOutput("sliceY", int'(FruitY), 414);
        repeat (7) frame();
        checkOutput("holdBusy7", int'(busy), 1);
        checkOutput("holdY7", int'(FruitY), 414);
        frame();
        checkOutput("holdBusy8", int'(busy), 0);
        checkOutput("holdSize8", int'(Fruit_size), 0);
        checkOutput("holdNoMiss", int'(sawMissed), 0);

        // Reset in the middle of a flight, relaunch right after release.
        launchFruit(100, 3, -10);
        repeat (10) frame();
        #1 Reset_n = 1'b0;
        #1;
        checkOutput("midResetX", int'(FruitX), 0);
        checkOutput("midResetY", int'(FruitY), 448);
        checkOutput("midResetBusy", int'(busy), 0);
        checkOutput("midResetSize", int'(Fruit_size), 0);
        applyStimulus();
        Reset_n = 1'b1;
        launchFruit(200, 1, -5);
        checkOutput("postResetBusy", int'(busy), 1);
        checkOutput("postResetX", int'(FruitX), 200);
        flyOut("postResetFlyOut");

        // Launch held high: no reload mid-flight, relaunch right after miss.
        sawMissed = 0;
        missTick  = 0;
        launch    = 1'b1;
        launch_x  = 10'd50;
        launch_vx = 6'(2);
        launch_vy = 6'(-6);
        applyStimulus();
        for (int t = 1; t <= 60 && missTick == 0; t++) begin
            frame();
            if (sawMissed) missTick = t;
        end
        checkOutput("heldMissTick", missTick, 13);
        checkOutput("relaunchBusy", int'(busy), 1);
        checkOutput("relaunchX", int'(FruitX), 50);
        checkOutput("relaunchY", int'(FruitY), 448);
        launch = 1'b0;
        flyOut("heldFlyOut");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            launch   = ($urandom_range(0, 9) == 0);
            launch_x = 10'($urandom);
            v        = int'($urandom_range(0, 40)) - 20;
            launch_vx = 6'(v);
            if ($urandom_range(0, 3) == 0) begin
                launch_vy = 6'($urandom);
            end else begin
                v = -(8 + int'($urandom_range(0, 20)));
                launch_vy = 6'(v);
            end
            slice_hit = ($urandom_range(0, 149) == 0);
            applyStimulus();
        end

        launch    = 1'b0;
        slice_hit = 1'b0;
        frame_clk = 1'b0;
        repeat (5) applyStimulus();
        #1;
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
